projectile_scheduler: RTL and testbench



---
 rtl/projectile_scheduler.sv | 129 ++++++++++++
 tb/tb_projectile_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : projectile_scheduler
// Brief    : Four-slot player projectile pool: fire-edge allocation with
//            cooldown, centred spawn, per-step upward motion, retirement.
// Revision : 1.0 - initial release
// ============================================================================
module projectile_scheduler #(
    parameter int PROJ_W       = 10,
    parameter int PROJ_H       = 10,
    parameter int PROJ_STEP    = 4,
    parameter int TOP_BOUNDARY = 35,
    parameter int COOLDOWN     = 8
) (
    input  logic        clk_master,
    input  logic        rst,
    input  logic        pulse_stepCycle,
    input  logic        fire,
    input  logic        gameActive,
    input  logic [9:0]  playerX,
    input  logic [8:0]  playerY,
    input  logic [9:0]  playerW,
    input  logic [3:0]  slotHit,
    output logic [3:0]  projActive,
    output logic [39:0] projX,
    output logic [35:0] projY,
    output logic        shotFired,
    output logic        cooldownBusy
);

    localparam logic [9:0] c_top_y         = 10'(TOP_BOUNDARY);
    localparam logic [9:0] c_retire_y      = 10'(TOP_BOUNDARY + PROJ_STEP);
    localparam logic [3:0] c_cooldown_load = 4'(COOLDOWN);

    logic [3:0]  r_proj_active_q, w_proj_active_d;
    logic [39:0] r_proj_x_q,      w_proj_x_d;
    logic [35:0] r_proj_y_q,      w_proj_y_d;
    logic        r_shot_fired_q,  w_shot_fired_d;
    logic [3:0]  r_cooldown_q,    w_cooldown_d;
    logic        r_fire_q,        w_fire_d;

    logic        w_fire_req;
    logic [3:0]  w_free;
    logic [3:0]  w_alloc_oh;
    logic [10:0] w_w_diff;
    logic [9:0]  w_spawn_x;
    logic [9:0]  w_spawn_y_full;
    logic        w_spawn_y_ok;
    logic        w_accept;

    assign w_fire_req = fire & ~r_fire_q;
    assign w_free     = ~r_proj_active_q;
    // Isolate the lowest set bit: lowest-index free slot as a one-hot.
    assign w_alloc_oh = w_free & (~w_free + 4'd1);

    assign w_w_diff       = 11'(playerW) - 11'(PROJ_W);
    assign w_spawn_x      = 10'(11'(playerX) + (w_w_diff >> 1));
    assign w_spawn_y_full = 10'(playerY) - 10'(PROJ_H);
    assign w_spawn_y_ok   = (w_spawn_y_full >= c_top_y);

    assign w_accept = w_fire_req & gameActive & (r_cooldown_q == 4'd0)
                    & (|w_free) & w_spawn_y_ok;

    always_comb begin
        w_proj_active_d = r_proj_active_q;
        w_proj_x_d      = r_proj_x_q;
        w_proj_y_d      = r_proj_y_q;
        w_shot_fired_d  = w_accept;
        w_fire_d        = fire;
        w_cooldown_d    = r_cooldown_q;

        if (!gameActive) begin
            w_cooldown_d = 4'd0;
        end else if (w_accept) begin
            w_cooldown_d = c_cooldown_load;
        end else if (pulse_stepCycle && (r_cooldown_q != 4'd0)) begin
            w_cooldown_d = r_cooldown_q - 4'd1;
        end

        // A freshly allocated slot was inactive before this edge, so the
        // spawn branch never competes with hit or step for the same slot.
        for (int i = 0; i < 4; i++) begin
            if (!gameActive) begin
                w_proj_active_d[i] = 1'b0;
            end else if (r_proj_active_q[i]) begin
                if (slotHit[i]) begin
                    w_proj_active_d[i] = 1'b0;
                end else if (pulse_stepCycle) begin
                    if ({1'b0, r_proj_y_q[i*9 +: 9]} < c_retire_y) begin
                        w_proj_active_d[i] = 1'b0;
                    end else begin
                        w_proj_y_d[i*9 +: 9] = r_proj_y_q[i*9 +: 9] - 9'(PROJ_STEP);
                    end
                end
            end else if (w_accept && w_alloc_oh[i]) begin
                w_proj_active_d[i]    = 1'b1;
                w_proj_x_d[i*10 +: 10] = w_spawn_x;
                w_proj_y_d[i*9 +: 9]   = w_spawn_y_full[8:0];
            end
        end
    end

    always_ff @(posedge clk_master) begin
        if (rst) begin
            r_proj_active_q <= 4'd0;
            r_proj_x_q      <= 40'd0;
            r_proj_y_q      <= 36'd0;
            r_shot_fired_q  <= 1'b0;
            r_cooldown_q    <= 4'd0;
            r_fire_q        <= 1'b0;
        end else begin
            r_proj_active_q <= w_proj_active_d;
            r_proj_x_q      <= w_proj_x_d;
            r_proj_y_q      <= w_proj_y_d;
            r_shot_fired_q  <= w_shot_fired_d;
            r_cooldown_q    <= w_cooldown_d;
            r_fire_q        <= w_fire_d;
        end
    end

    assign projActive   = r_proj_active_q;
    assign projX        = r_proj_x_q;
    assign projY        = r_proj_y_q;
    assign shotFired    = r_shot_fired_q;
    assign cooldownBusy = (r_cooldown_q != 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_projectile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_projectile_scheduler
// Brief    : Scoreboard bench for projectile_scheduler: directed scenarios
//            plus random traffic against a slot-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_projectile_scheduler;

    localparam int PROJ_W       = 10;
    localparam int PROJ_H       = 10;
    localparam int PROJ_STEP    = 4;
    localparam int TOP_BOUNDARY = 35;
    localparam int COOLDOWN     = 8;

    logic        clk_master = 1'b0;
    logic        rst, pulse_stepCycle, fire, gameActive;
    logic [9:0]  playerX, playerW;
    logic [8:0]  playerY;
    logic [3:0]  slotHit;
    logic [3:0]  projActive;
    logic [39:0] projX;
    logic [35:0] projY;
    logic        shotFired, cooldownBusy;

    always #5 clk_master = ~clk_master;

    projectile_scheduler #(
        .PROJ_W(PROJ_W), .PROJ_H(PROJ_H), .PROJ_STEP(PROJ_STEP),
        .TOP_BOUNDARY(TOP_BOUNDARY), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk_master(clk_master), .rst(rst), .pulse_stepCycle(pulse_stepCycle),
        .fire(fire), .gameActive(gameActive), .playerX(playerX),
        .playerY(playerY), .playerW(playerW), .slotHit(slotHit),
        .projActive(projActive), .projX(projX), .projY(projY),
        .shotFired(shotFired), .cooldownBusy(cooldownBusy)
    );

    typedef struct packed {
        logic [3:0]  act;
        logic [39:0] x;
        logic [35:0] y;
        logic        shot;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   shots_seen = 0;
    bit   armed      = 1'b0;

    // Reference model: a list of four slots, each either in flight or idle.
    int m_x[4], m_y[4];
    bit m_act[4];
    int m_cd;
    bit m_fq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_master) begin : model
        exp_t e;
        int   free_slot, sx, sy;
        bit   req, accept;
        accept = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd  = 0;
            m_fq  = 1'b0;
            armed = 1'b1;
        end else begin
            req  = fire && !m_fq;
            m_fq = fire;
            free_slot = -1;
            for (int i = 3; i >= 0; i--) if (!m_act[i]) free_slot = i;
            sx = (int'(playerX) + (int'(playerW) - PROJ_W) / 2) % 1024;
            sy = int'(playerY) - PROJ_H;
            accept = req && gameActive && (m_cd == 0) && (free_slot >= 0)
                     && (sy >= TOP_BOUNDARY);
            if (!gameActive) begin
                for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
                m_cd = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (m_act[i]) begin
                        if (slotHit[i]) m_act[i] = 1'b0;
                        else if (pulse_stepCycle) begin
                            if (m_y[i] < TOP_BOUNDARY + PROJ_STEP) m_act[i] = 1'b0;
                            else m_y[i] = m_y[i] - PROJ_STEP;
                        end
                    end
                end
                if (accept) begin
                    m_act[free_slot] = 1'b1;
                    m_x[free_slot]   = sx;
                    m_y[free_slot]   = sy;
                    m_cd             = COOLDOWN;
                end else if (pulse_stepCycle && m_cd > 0) begin
                    m_cd = m_cd - 1;
                end
            end
        end
        if (armed) begin
            for (int i = 0; i < 4; i++) begin
                e.act[i]        = m_act[i];
                e.x[i*10 +: 10] = 10'(m_x[i]);
                e.y[i*9 +: 9]   = 9'(m_y[i]);
            end
            e.shot = accept;
            e.busy = (m_cd != 0);
            exp_q.push_back(e);
        end
    end

    always @(posedge clk_master) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_projActive",   projActive,   e.act);
            chk("sb_projX",        projX,        e.x);
            chk("sb_projY",        projY,        e.y);
            chk("sb_shotFired",    shotFired,    e.shot);
            chk("sb_cooldownBusy", cooldownBusy, e.busy);
            if (shotFired === 1'b1) shots_seen++;
        end else if (armed) begin
            chk("sb_queue_empty", 1, 0);
        end
    end

    task automatic tick(input bit f, input bit s, input logic [3:0] h, input bit ga, input bit r);
        @(negedge clk_master);
        fire = f; pulse_stepCycle = s; slotHit = h; gameActive = ga; rst = r;
    endtask

    task automatic settle();
        @(posedge clk_master);
        #2;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  base;
        bit  fstate;
        rst = 1'b1; fire = 1'b0; pulse_stepCycle = 1'b0; slotHit = 4'd0;
        gameActive = 1'b1; playerX = 10'd449; playerY = 9'd450; playerW = 10'd30;
        tick(0, 0, 4'd0, 1, 1);
        tick(0, 0, 4'd0, 1, 1);

        // First press, then hold for 100 cycles with 20 step pulses.
        tick(1, 0, 4'd0, 1, 0);
        settle();
        chk("spawn_active", projActive, 4'b0001);
        chk("spawn_x0", projX[9:0], 459);
        chk("spawn_y0", projY[8:0], 440);
        chk("spawn_shot", shotFired, 1);
        chk("spawn_busy", cooldownBusy, 1);
        base = shots_seen;
        for (int i = 0; i < 100; i++) tick(1, (i % 5) == 4, 4'd0, 1, 0);
        settle();
        chk("hold_extra_shots", shots_seen - base, 0);
        chk("hold_cooldown_idle", cooldownBusy, 0);
        tick(0, 0, 4'd0, 1, 0);
        tick(1, 0, 4'd0, 1, 0);
        settle();
        chk("repress_shot", shotFired, 1);
        chk("repress_slots", projActive, 4'b0011);

        // Five presses nine steps apart: four fill, fifth dropped.
        tick(0, 0, 4'd0, 1, 1);
        base = shots_seen;
        repeat (5) begin
            tick(1, 0, 4'd0, 1, 0);
            repeat (9) tick(0, 1, 4'd0, 1, 0);
        end
        settle();
        chk("fill_shot_count", shots_seen - base, 4);
        chk("fill_active", projActive, 4'hF);

        // Retirement at the top boundary and reuse of slot 0.
        tick(0, 0, 4'd0, 1, 1);
        playerY = 9'd50;
        tick(1, 0, 4'd0, 1, 0);
        tick(0, 1, 4'd0, 1, 0);
        settle();
        chk("step_y0", projY[8:0], 36);
        chk("step_alive", projActive, 4'b0001);
        tick(0, 1, 4'd0, 1, 0);
        settle();
        chk("retire_active", projActive, 4'b0000);
        repeat (6) tick(0, 1, 4'd0, 1, 0);
        tick(1, 0, 4'd0, 1, 0);
        settle();
        chk("reuse_slot0", projActive, 4'b0001);
        chk("reuse_y0", projY[8:0], 40);
        playerY = 9'd450;

        // Hit frees slot 1 only for the following cycle.
        tick(0, 0, 4'd0, 1, 1);
        repeat (4) begin
            tick(1, 0, 4'd0, 1, 0);
            repeat (8) tick(0, 1, 4'd0, 1, 0);
        end
        tick(1, 1, 4'b0010, 1, 0);
        settle();
        chk("hit_clears_slot1", projActive, 4'b1101);
        chk("hit_drop_shot", shotFired, 0);
        tick(0, 0, 4'd0, 1, 0);
        tick(1, 0, 4'd0, 1, 0);
        settle();
        chk("hit_retry_shot", shotFired, 1);
        chk("hit_retry_full", projActive, 4'hF);

        // gameActive drop, ignored fire, then reset mid-flight.
        tick(0, 0, 4'd0, 1, 1);
        repeat (2) begin
            tick(1, 0, 4'd0, 1, 0);
            repeat (8) tick(0, 1, 4'd0, 1, 0);
        end
        tick(1, 0, 4'd0, 1, 0);
        repeat (3) tick(0, 1, 4'd0, 1, 0);
        settle();
        chk("pre_drop_active", projActive, 4'b0111);
        chk("pre_drop_busy", cooldownBusy, 1);
        tick(0, 0, 4'd0, 0, 0);
        settle();
        chk("drop_active", projActive, 4'b0000);
        chk("drop_busy", cooldownBusy, 0);
        tick(1, 0, 4'd0, 0, 0);
        settle();
        chk("inactive_no_shot", shotFired, 0);
        tick(0, 0, 4'd0, 1, 0);
        tick(1, 0, 4'd0, 1, 0);
        settle();
        chk("resume_shot", shotFired, 1);
        tick(0, 0, 4'd0, 1, 1);
        settle();
        chk("rst_active", projActive, 4'b0000);
        chk("rst_x", projX, 0);
        chk("rst_y", projY, 0);
        chk("rst_busy", cooldownBusy, 0);

        // Random traffic.
        fstate = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) fstate = ~fstate;
            if ($urandom_range(0, 63) == 0) begin
                playerX = 10'($urandom_range(0, 600));
                playerY = 9'($urandom_range(10, 479));
                playerW = 10'($urandom_range(10, 200));
            end
            tick(fstate,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 $urandom_range(0, 79) != 0,
                 $urandom_range(0, 799) == 0);
        end
        tick(0, 0, 4'd0, 1, 0);
        settle();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
